dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter/sequencer that shares the single 64-word data memory between two requesters: port 0 is the CPU load/store path and port 1 is a debug/DMA loader.
- It registers each request, generates one-cycle MemRead/MemWrite strobes, captures read data and returns a response pulse to the winning requester.
- Sits between the requesters and the data memory. No other block drives the memory control inputs.

Parameters:
- REG_BITS, 32, data and address width (32 or 16).
- DEPTH, 64, number of memory words; valid word addresses are 0..DEPTH-1.
- ADDR_BITS, 6, log2(DEPTH); width of the address actually driven to memory.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- m0_req  input  1  port 0 request; held high with fields stable until m0_gnt.
- m0_we  input  1  port 0: 1 = write, 0 = read.
- m0_addr  input  REG_BITS  port 0 word address.
- m0_wdata  input  REG_BITS  port 0 write data.
- m0_gnt  output  1  port 0 request captured (1-cycle pulse).
- m0_rvalid  output  1  port 0 response valid (1-cycle pulse).
- m0_rdata  output  REG_BITS  port 0 read data; valid only with m0_rvalid.
- m0_err  output  1  port 0 error flag; valid only with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: identical set for port 1.
- mem_read  output  1  to memory MemRead.
- mem_write  output  1  to memory MemWrite.
- mem_addr  output  REG_BITS  to memory addr; upper bits above ADDR_BITS are always 0.
- mem_wdata  output  REG_BITS  to memory write_data.
- mem_rdata  input  REG_BITS  from memory read_data.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE and the round-robin pointer last_win is set to 1.
  - All outputs go to 0: gnt, rvalid, rdata, err, mem_read, mem_write, mem_addr, mem_wdata.
- Reset mid-transaction abandons the transaction: strobes drop on that edge, no rvalid is issued, and the memory contents are whatever the strobe already did.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If any req is high, pick the winner: sole requester wins; if both are high, the port not equal to last_win wins.
  - Latch the winner's we/addr/wdata, set last_win = winner, go to ACCESS.
  - If no req, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Winner's gnt = 1.
  - mem_addr = latched addr[ADDR_BITS-1:0], zero-extended; mem_wdata = latched wdata.
  - mem_read = !we, mem_write = we.
  - At the end of the cycle capture mem_rdata for a read, or 0 for a write. Go to RESP.
- RESP (exactly 1 cycle):
  - Strobes are 0 and mem_addr/mem_wdata hold.
  - Winner's rvalid = 1 with rdata/err. The loser's rvalid, rdata and err are 0.
  - Go to IDLE.
- Latency: req sampled in IDLE at cycle N gives gnt and strobe at N+1 and rvalid at N+2. Peak throughput is one access per 3 cycles.
- Writes also receive rvalid (acknowledge) with rdata = 0.
- After gnt the requester may drop req or present a new request. A req still high in the RESP cycle is arbitrated in the next IDLE.
- Fairness:
  - With both ports requesting continuously, grants alternate 0,1,0,1,...
  - Port 0 wins the first simultaneous request after reset.
- Requests arriving while in ACCESS or RESP are not sampled until IDLE.
- Address handling (without the optional feature): addr is truncated to its low ADDR_BITS. Address 64 aliases to 0 and 65 aliases to 1. err is always 0.
- mem_read and mem_write are never high together and are never high outside ACCESS.

Optional Feature:
- Macro: DMEM_ARB_RANGE_CHECK_EN.
- Defined:
  - If latched addr >= DEPTH, ACCESS asserts gnt but keeps mem_read and mem_write at 0, so memory is not touched.
  - RESP asserts rvalid with err = 1 and rdata = 0.
  - In-range accesses are unchanged.
- Not defined: no range comparison; truncation and wrap-around as described in Behaviour; err is tied to 0.

Test Plan:
- Reset check: hold rst_n = 0 for 2 cycles with m0_req = 1 -> all outputs 0 and no gnt; release -> m0_gnt 1 cycle later, m0_rvalid the cycle after.
- Port 0 write then read: write addr 5 data 0xDEADBEEF, then read addr 5 -> mem_write pulses 1 cycle with mem_addr = 5; the read returns m0_rdata = 0xDEADBEEF with m0_rvalid 2 cycles after req is sampled.
- Contention: m0_req and m1_req held high for 4 grants -> grant order 0,1,0,1, one rvalid per grant, 3 cycles apart, and the loser's rvalid stays 0.
- Boundary address:
  - Without the macro: write 0x1234 to addr 64, then read addr 0 -> 0x1234.
  - With DMEM_ARB_RANGE_CHECK_EN: write to addr 64 -> no mem_write strobe and err = 1; a read of addr 0 then returns the earlier value.
  - Addr 63 works normally in both builds.
- Reset mid-operation: assert rst_n = 0 during the ACCESS cycle of a port 1 read -> no m1_rvalid, strobes 0 the next cycle, last_win = 1; a following simultaneous request is granted to port 0.
- Strobe exclusivity: random back-to-back read/write traffic for 200 cycles -> mem_read and mem_write are never high together and are high only in ACCESS cycles.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the shared 64-word data memory.
// Optional out-of-range blocking with error response: define DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter #(
  parameter int REG_BITS  = 32,
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [REG_BITS-1:0] m0_addr,
  input  logic [REG_BITS-1:0] m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [REG_BITS-1:0] m0_rdata,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [REG_BITS-1:0] m1_addr,
  input  logic [REG_BITS-1:0] m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [REG_BITS-1:0] m1_rdata,
  output logic                m1_err,
  output logic                mem_read,
  output logic                mem_write,
  output logic [REG_BITS-1:0] mem_addr,
  output logic [REG_BITS-1:0] mem_wdata,
  input  logic [REG_BITS-1:0] mem_rdata,
  output logic [1:0]          dbg_state
);

  // Handshake: a requester holds req high with stable fields until its gnt
  // pulse; the matching rvalid pulse follows exactly one cycle after gnt.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                     r_last_win;
  logic                     r_win;
  logic                     r_we;
  logic                     r_oor;
  logic [1:0]               r_gnt;
  logic [1:0]               r_rvalid;
  logic [1:0]               r_err;
  logic [1:0][REG_BITS-1:0] r_rdata;
  logic                     r_mem_read;
  logic                     r_mem_write;
  logic [REG_BITS-1:0]      r_mem_addr;
  logic [REG_BITS-1:0]      r_mem_wdata;

  logic                w_any;
  logic                w_win;
  logic                w_sel_we;
  logic [REG_BITS-1:0] w_sel_addr;
  logic [REG_BITS-1:0] w_sel_wdata;
  logic                w_sel_oor;

  // On a tie the port that did not win last time takes the grant.
  always_comb begin
    w_any       = m0_req | m1_req;
    w_win       = (m0_req & m1_req) ? ~r_last_win : m1_req;
    w_sel_we    = w_win ? m1_we    : m0_we;
    w_sel_addr  = w_win ? m1_addr  : m0_addr;
    w_sel_wdata = w_win ? m1_wdata : m0_wdata;
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  assign w_sel_oor = (w_sel_addr >= REG_BITS'(DEPTH));
  assign m0_err    = r_err[0];
  assign m1_err    = r_err[1];
`else
  logic w_unused_bits;
  assign w_sel_oor     = 1'b0;
  assign m0_err        = 1'b0;
  assign m1_err        = 1'b0;
  assign w_unused_bits = ^{w_sel_addr[REG_BITS-1:ADDR_BITS], r_err};
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Outputs are loaded one state ahead so that every output is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_win  <= 1'b1;
      r_win       <= 1'b0;
      r_we        <= 1'b0;
      r_oor       <= 1'b0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_err       <= '0;
      r_rdata     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win       <= w_win;
            r_last_win  <= w_win;
            r_we        <= w_sel_we;
            r_oor       <= w_sel_oor;
            r_gnt       <= w_win ? 2'b10 : 2'b01;
            r_mem_read  <= ~w_sel_we & ~w_sel_oor;
            r_mem_write <= w_sel_we & ~w_sel_oor;
            r_mem_addr  <= REG_BITS'(w_sel_addr[ADDR_BITS-1:0]);
            r_mem_wdata <= w_sel_wdata;
          end
        end
        S_ACCESS: begin
          r_gnt          <= '0;
          r_mem_read     <= 1'b0;
          r_mem_write    <= 1'b0;
          r_rvalid       <= r_win ? 2'b10 : 2'b01;
          r_rdata[r_win] <= (r_we | r_oor) ? '0 : mem_rdata;
          r_err[r_win]   <= r_oor;
        end
        S_RESP: begin
          r_rvalid <= '0;
          r_rdata  <= '0;
          r_err    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign m0_gnt    = r_gnt[0];
  assign m1_gnt    = r_gnt[1];
  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];
  assign m0_rdata  = r_rdata[0];
  assign m1_rdata  = r_rdata[1];
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-word memory and a
// short randomised traffic phase scored against a shadow memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  logic [31:0] tb_mem [64];
  logic [31:0] shadow [64];
  bit          mem_init;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          n_cmp;
  int          n_err;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: combinational read while MemRead, write on the clock edge
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= 32'hA000_0000 | i;
      mem_init <= 1'b1;
    end else if (mem_write) begin
      tb_mem[mem_addr[5:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_read ? tb_mem[mem_addr[5:0]] : 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one complete transaction started from IDLE
  task automatic xfer(input int p, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic exp_err, input logic exp_stb);
    if (p == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
    step();
    chk("gnt", (p == 0) ? m0_gnt : m1_gnt, 32'd1);
    chk("gnt_other", (p == 0) ? m1_gnt : m0_gnt, 32'd0);
    chk("mem_write", mem_write, we & exp_stb);
    chk("mem_read", mem_read, ~we & exp_stb);
    if (exp_stb) chk("mem_addr", mem_addr, {26'b0, addr[5:0]});
    if (exp_stb && we) chk("mem_wdata", mem_wdata, wdata);
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
    chk("rvalid", (p == 0) ? m0_rvalid : m1_rvalid, 32'd1);
    chk("rvalid_other", (p == 0) ? m1_rvalid : m0_rvalid, 32'd0);
    chk("rdata", (p == 0) ? m0_rdata : m1_rdata, exp_rd);
    chk("err", (p == 0) ? m0_err : m1_err, exp_err);
    chk("strobes_resp", {mem_read, mem_write}, 32'd0);
    step();
    chk("rvalid_drop", {m1_rvalid, m0_rvalid}, 32'd0);
  endtask

  initial begin
    int w;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

    // reset held two cycles with a pending port 0 read of address 0
    m0_req = 1'b1;
    step();
    step();
    chk("rst_flags", {m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err,
                      mem_read, mem_write}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_gnt", m0_gnt, 32'd1);
    chk("post_rst_read", mem_read, 32'd1);
    m0_req = 1'b0;
    step();
    chk("post_rst_rvalid", m0_rvalid, 32'd1);
    chk("post_rst_rdata", m0_rdata, 32'hA000_0000);
    step();
    chk("post_rst_idle", {m0_gnt, m0_rvalid}, 32'd0);

    // port 0 write then read back
    xfer(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
    xfer(0, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1);

    // boundary addresses
`ifdef DMEM_ARB_RANGE_CHECK_EN
    xfer(0, 1'b1, 32'd64, 32'h0000_1234, 32'd0, 1'b1, 1'b0);
    xfer(0, 1'b0, 32'd0, 32'd0, 32'hA000_0000, 1'b0, 1'b1);
    xfer(1, 1'b0, 32'd65, 32'd0, 32'd0, 1'b1, 1'b0);
`else
    xfer(0, 1'b1, 32'd64, 32'h0000_1234, 32'd0, 1'b0, 1'b1);
    xfer(0, 1'b0, 32'd0, 32'd0, 32'h0000_1234, 1'b0, 1'b1);
    xfer(1, 1'b0, 32'd65, 32'd0, 32'hA000_0001, 1'b0, 1'b1);
`endif
    xfer(1, 1'b1, 32'd63, 32'h0BAD_F00D, 32'd0, 1'b0, 1'b1);
    xfer(0, 1'b0, 32'd63, 32'd0, 32'h0BAD_F00D, 1'b0, 1'b1);

    // port 1 wins last, so continuous contention must start with port 0
    xfer(1, 1'b1, 32'd20, 32'h5555_0014, 32'd0, 1'b0, 1'b1);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd20;
    for (int k = 0; k < 12; k++) begin
      step();
      w = (k / 3) % 2;
      chk("cont_gnt", {m1_gnt, m0_gnt}, (k % 3 == 0) ? ((w != 0) ? 32'd2 : 32'd1) : 32'd0);
      chk("cont_rvalid", {m1_rvalid, m0_rvalid}, (k % 3 == 1) ? ((w != 0) ? 32'd2 : 32'd1) : 32'd0);
      if (k % 3 == 1)
        chk("cont_rdata", (w != 0) ? m1_rdata : m0_rdata, (w != 0) ? 32'h5555_0014 : 32'hA000_000A);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;

    // reset during the ACCESS cycle of a port 1 read
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd7;
    step();
    chk("midrst_gnt", m1_gnt, 32'd1);
    rst_n = 1'b0;
    m1_req = 1'b0;
    step();
    chk("midrst_strobes", {mem_read, mem_write, m1_gnt}, 32'd0);
    chk("midrst_rvalid", m1_rvalid, 32'd0);
    rst_n = 1'b1;
    step();
    chk("midrst_no_rvalid", {m1_rvalid, m0_rvalid}, 32'd0);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd3;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd4;
    step();
    chk("midrst_tie_gnt", {m1_gnt, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
    chk("midrst_tie_rdata", m0_rdata, 32'hA000_0003);
    step();

    // random protocol-correct traffic scored against a shadow memory
    for (int i = 0; i < 64; i++) shadow[i] = tb_mem[i];
    for (int c = 0; c < 200; c++) begin
      step();
      chk("strobe_excl", mem_read & mem_write, 32'd0);
      chk("strobe_outside_access", (mem_read | mem_write) & ~(m0_gnt | m1_gnt), 32'd0);
      chk("mem_addr_hi", mem_addr[31:6], 32'd0);
      if (m0_gnt) begin
        if (m0_we) begin
          shadow[m0_addr[5:0]] = m0_wdata;
          exp_q0.push_back(32'd0);
        end else begin
          exp_q0.push_back(shadow[m0_addr[5:0]]);
        end
        m0_req = 1'b0;
      end
      if (m1_gnt) begin
        if (m1_we) begin
          shadow[m1_addr[5:0]] = m1_wdata;
          exp_q1.push_back(32'd0);
        end else begin
          exp_q1.push_back(shadow[m1_addr[5:0]]);
        end
        m1_req = 1'b0;
      end
      if (m0_rvalid) begin
        chk("rsp0_pending", exp_q0.size() != 0, 32'd1);
        if (exp_q0.size() != 0) chk("rsp0_data", m0_rdata, exp_q0.pop_front());
      end
      if (m1_rvalid) begin
        chk("rsp1_pending", exp_q1.size() != 0, 32'd1);
        if (exp_q1.size() != 0) chk("rsp1_data", m1_rdata, exp_q1.pop_front());
      end
      if (c < 188 && !m0_req && $urandom_range(0, 1) == 1) begin
        m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1));
        m0_addr = $urandom_range(0, 63); m0_wdata = $urandom;
      end
      if (c < 188 && !m1_req && $urandom_range(0, 1) == 1) begin
        m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1));
        m1_addr = $urandom_range(0, 63); m1_wdata = $urandom;
      end
    end
    chk("q0_drained", exp_q0.size(), 32'd0);
    chk("q1_drained", exp_q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
